// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for seg7_scan_decoder: capture/clear strobes in, registered segment drive out.
// The master drives data and strobes; the slave (the decoder) drives the display lines.
interface seg7_scan_decoder_if;
    logic [7:0] data_in;
    logic       zero_in;
    logic       load;
    logic       clear;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;

    modport master (
        output data_in,
        output zero_in,
        output load,
        output clear,
        input  seg,
        input  dp,
        input  digit_en
    );

    modport slave (
        input  data_in,
        input  zero_in,
        input  load,
        input  clear,
        output seg,
        output dp,
        output digit_en
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Two-digit multiplexed 7-segment hex display driver with registered segment/digit outputs.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks a zero high digit during its time slot.
module seg7_scan_decoder #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input logic                 clk,
    input logic                 reset,
    seg7_scan_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        StBlank  = 2'd0,
        StShowLo = 2'd1,
        StShowHi = 2'd2
    } state_e;

    localparam logic [15:0] LastCnt = REFRESH_DIV - 16'd1;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  value_q, value_d;
    logic        zero_q, zero_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [1:0]  digit_en_q, digit_en_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next state, slot counter and latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        zero_d  = zero_q;

        if (bus.clear) begin
            state_d = StBlank;
            cnt_d   = '0;
        end else begin
            if (bus.load) begin
                value_d = bus.data_in;
                zero_d  = bus.zero_in;
            end
            case (state_q)
                StBlank: begin
                    if (bus.load) begin
                        state_d = StShowLo;
                        cnt_d   = '0;
                    end
                end
                StShowLo, StShowHi: begin
                    // A load while scanning only refreshes the latches; slot timing runs on.
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = (state_q == StShowLo) ? StShowHi : StShowLo;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output image derived from the current state and latches, registered one clock later.
    always_comb begin
        seg_d      = 7'h00;
        dp_d       = 1'b0;
        digit_en_d = 2'b00;
        case (state_q)
            StShowLo: begin
                digit_en_d = 2'b01;
                seg_d      = hex_to_seg(value_q[3:0]);
                dp_d       = zero_q;
            end
            StShowHi: begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (value_q[7:4] != 4'h0) begin
                    digit_en_d = 2'b10;
                    seg_d      = hex_to_seg(value_q[7:4]);
                end
`else
                digit_en_d = 2'b10;
                seg_d      = hex_to_seg(value_q[7:4]);
`endif
            end
            default: begin
                seg_d      = 7'h00;
                dp_d       = 1'b0;
                digit_en_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBlank;
            cnt_q      <= '0;
            value_q    <= 8'h00;
            zero_q     <= 1'b0;
            seg_q      <= 7'h00;
            dp_q       <= 1'b0;
            digit_en_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            zero_q     <= zero_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.digit_en = digit_en_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (digit_en_q != 2'b11);
            assert (cnt_q <= LastCnt);
        end
    end
`endif

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 16'd50000: clk cycles per digit time slot; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  8  byte to display as two hex digits.
REQ-005 SHALL have port zero_in  input  1  zero flag to display on the low-digit decimal point.
REQ-006 SHALL have port load  input  1  single-cycle strobe; captures data_in and zero_in.
REQ-007 SHALL have port clear  input  1  single-cycle strobe; returns display to blank.
REQ-008 SHALL have port seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp  output  1  active-high decimal point.
REQ-010 SHALL have port digit_en  output  2  one-hot digit enable, bit0 = low nibble, bit1 = high nibble, active-high.

Function
REQ-011 SHALL hold an 8-bit value latch and a 1-bit zero latch, written on the clk edge where load=1 and clear=0.
REQ-012 SHALL implement states BLANK, SHOW_LO and SHOW_HI.
REQ-013 SHALL move BLANK->SHOW_LO on load; a load in SHOW_LO or SHOW_HI SHALL update the latches only, with no state or counter change.
REQ-014 SHALL keep a refresh counter 0..REFRESH_DIV-1 while in SHOW_*; at terminal count it SHALL wrap to 0 and toggle SHOW_LO<->SHOW_HI.
REQ-015 SHALL reset the refresh counter to 0 on the BLANK->SHOW_LO transition.
REQ-016 SHALL go to BLANK from any state on clear, clearing the counter; the latches SHALL be unchanged.
REQ-017 SHALL give clear priority over load when both are asserted in the same cycle: state BLANK, latches unchanged.
REQ-018 SHALL register seg, dp and digit_en; outputs SHALL reflect state and latches one clk after they change.
REQ-019 SHALL drive, in BLANK: seg=0, dp=0, digit_en=00.
REQ-020 SHALL drive, in SHOW_LO: digit_en=01, seg=hex(latch[3:0]), dp=zero latch.
REQ-021 SHALL drive, in SHOW_HI: digit_en=10, seg=hex(latch[7:4]), dp=0.
REQ-022 SHALL use this hex table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 SHALL give the low and high time slots exactly REFRESH_DIV clk cycles each, with no dead cycle between them.

Reset
REQ-024 SHALL on reset force state=BLANK, counter=0, value latch=8'h00, zero latch=0, seg=0, dp=0, digit_en=00.
REQ-025 SHALL let reset override load and clear; reset mid-slot SHALL abort scanning immediately at that edge.

Configuration
REQ-026 SHALL support macro SEG7_LEADING_ZERO_BLANK_EN.
REQ-027 With SEG7_LEADING_ZERO_BLANK_EN defined: in SHOW_HI with latch[7:4]=0, the outputs SHALL be digit_en=00 and seg=0; the slot still lasts REFRESH_DIV cycles.
REQ-028 Without the macro: the high digit SHALL always be shown, with "0" displayed as 3F.

Verification (REFRESH_DIV=4)
REQ-029 SHALL check: reset held 3 cycles, then idle 10 cycles -> seg=0, dp=0, digit_en=00 throughout.
REQ-030 SHALL check: load data_in=8'hA5, zero_in=0 -> next edge digit_en=01, seg=6D for 4 cycles, then digit_en=10, seg=77 for 4 cycles, alternating.
REQ-031 SHALL check: load 8'h00 with zero_in=1 -> low slot seg=3F, dp=1; high slot digit_en=00 with macro, or seg=3F, dp=0 without.
REQ-032 SHALL check: in SHOW_HI, load 8'h3C -> next edge seg=4F with the slot not restarted; the following low slot shows seg=39.
REQ-033 SHALL check: load and clear asserted together while showing 8'h12 -> BLANK outputs; a later load 8'h12 restarts from SHOW_LO with seg=5B.
REQ-034 SHALL check: reset asserted 2 cycles into SHOW_LO -> at that edge all outputs and state match REQ-024.
